// File: rtl/sdram_request_arbiter.sv
// sdram_request_arbiter
// Shares one SDRAM controller between NUM_REQ requesters. A round-robin
// arbiter picks one instruction at a time and presents it as a one-entry
// FIFO. An in-order tag queue records which requester issued each read, so
// every returned read word can be routed back to its issuer.
// Build option: define ARB_STRICT_PRIORITY_EN to make the lowest eligible
// index always win. The round-robin pointer is then held at 0.
module sdram_request_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 13,
    parameter int BA_BITS   = 2,
    parameter int DQ_BITS   = 16,
    parameter int TAG_DEPTH = 4,
    parameter int INST_W    = ADDR_BITS + BA_BITS + DQ_BITS + 1
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [NUM_REQ-1:0]          Req_Valid,
    input  logic [NUM_REQ*INST_W-1:0]   Req_Instruction,
    output logic [NUM_REQ-1:0]          Req_Ready,
    output logic [NUM_REQ-1:0]          Rsp_Valid,
    output logic [DQ_BITS-1:0]          Rsp_Data,
    output logic [$clog2(NUM_REQ)-1:0]  Grant_Id,
    output logic [INST_W-1:0]           FIFO_In_Instruction,
    output logic                        FIFO_In_Empty,
    input  logic                        FIFO_In_Rd_En,
    input  logic                        FIFO_Out_DV,
    input  logic [DQ_BITS-1:0]          FIFO_Out_Data,
    output logic                        FIFO_Out_Full,
    output logic                        Tag_Overflow
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [0:0]         state_q,     state_d;
    logic [INST_W-1:0]  instr_q,     instr_d;
    logic [ID_W-1:0]    grant_q,     grant_d;
    logic [ID_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [PTR_W:0]     wr_ptr_q,    wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q,    rd_ptr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DQ_BITS-1:0] rsp_data_q,  rsp_data_d;
    logic               overflow_q,  overflow_d;

    logic [ID_W-1:0]    tag_mem_q [TAG_DEPTH];

    logic               tag_empty, tag_full;
    logic               tag_push, tag_pop;
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    search_base;
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    int                 sel_idx;

`ifdef ARB_STRICT_PRIORITY_EN
    assign search_base = '0;
`else
    assign search_base = rr_ptr_q;
`endif

    // Tag queue status and per-requester eligibility (reads need a free tag).
    always_comb begin
        tag_empty = (wr_ptr_q == rd_ptr_q);
        tag_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                    (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = Req_Valid[i] & (Req_Instruction[i*INST_W] | ~tag_full);
        end
    end

    // Winner search: first eligible index at or after the search base, wrapping.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
        win_found = 1'b0;
        win_id    = '0;
        sel_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_idx = (int'(search_base) + k) % NUM_REQ;
            if (!win_found && eligible[sel_idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = sel_idx[ID_W-1:0];
            end
        end
    end

    // Offer FSM: accept the winner in IDLE, hold it until the controller pops it.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        tag_push  = 1'b0;
        Req_Ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    // Rst_n gating keeps Ready low during a reset cycle.
                    Req_Ready[win_id] = Rst_n;
                    instr_d  = Req_Instruction[int'(win_id)*INST_W +: INST_W];
                    grant_d  = win_id;
                    state_d  = ST_OFFER;
`ifndef ARB_STRICT_PRIORITY_EN
                    rr_ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
`endif
                end
            end
            ST_OFFER: begin
                if (FIFO_In_Rd_En) begin
                    tag_push = ~instr_q[0];
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response routing: pop the head tag on each read word and steer it home.
    always_comb begin
        tag_pop     = FIFO_Out_DV & ~tag_empty;
        wr_ptr_d    = wr_ptr_q + (PTR_W+1)'(tag_push);
        rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(tag_pop);
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        overflow_d  = overflow_q | (FIFO_Out_DV & tag_empty);
        if (tag_pop) begin
            rsp_valid_d[tag_mem_q[rd_ptr_q[PTR_W-1:0]]] = 1'b1;
            rsp_data_d = FIFO_Out_Data;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            overflow_q  <= overflow_d;
        end
    end

    // Tag storage: writes the granted requester id on each read pop.
    always_ff @(posedge Clk) begin
        // NOTE: the tag array is not reset; resetting the pointers makes it empty, and stale entries are never read.
        if (tag_push) begin
            tag_mem_q[wr_ptr_q[PTR_W-1:0]] <= grant_q;
        end
    end

    assign FIFO_In_Instruction = instr_q;
    assign FIFO_In_Empty       = (state_q == ST_IDLE);
    assign Grant_Id            = grant_q;
    assign Rsp_Valid           = rsp_valid_q;
    assign Rsp_Data            = rsp_data_q;
    assign Tag_Overflow        = overflow_q;
    assign FIFO_Out_Full       = 1'b0;

endmodule

// File: doc/sdram_request_arbiter.md
Name: sdram_request_arbiter

Overview:
Shares one SDRAM_Controller between NUM_REQ independent requesters. It accepts instructions over per-requester valid/ready handshakes and arbitrates them round-robin. To the controller it presents the winning instruction as a one-entry FIFO (FIFO_In_* interface). It tracks outstanding reads in an in-order tag queue and routes each returned read word (FIFO_Out_*) back to the requester that issued it.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_BITS, 13, row/column address width
BA_BITS, 2, bank address width
DQ_BITS, 16, data width
TAG_DEPTH, 4, max outstanding reads (power of 2)
INST_W, ADDR_BITS+BA_BITS+DQ_BITS+1, instruction width; layout {addr, bank, data, we}, bit 0 = we (1 = write)

Ports:
Clk  in  1  system clock, all logic on posedge
Rst_n  in  1  synchronous active-low reset
Req_Valid  in  NUM_REQ  per-requester instruction valid
Req_Instruction  in  NUM_REQ*INST_W  requester i occupies bits [i*INST_W +: INST_W]
Req_Ready  out  NUM_REQ  one-hot accept; transfer on Valid&Ready at posedge
Rsp_Valid  out  NUM_REQ  one-hot, one-cycle read-data valid
Rsp_Data  out  DQ_BITS  read data, shared by all requesters
Grant_Id  out  $clog2(NUM_REQ)  requester owning the currently offered instruction
FIFO_In_Instruction  out  INST_W  instruction offered to controller
FIFO_In_Empty  out  1  low = instruction offered
FIFO_In_Rd_En  in  1  controller pop pulse
FIFO_Out_DV  in  1  controller read-data valid, one pulse per read
FIFO_Out_Data  in  DQ_BITS  controller read data
FIFO_Out_Full  out  1  tied 0; responses never back-pressured
Tag_Overflow  out  1  sticky error flag

Behaviour:
- Reset (Rst_n=0 at posedge):
  - State goes to IDLE. FIFO_In_Empty=1, FIFO_In_Instruction=0, Grant_Id=0.
  - Req_Ready=0, Rsp_Valid=0, Rsp_Data=0, Tag_Overflow=0.
  - Round-robin pointer=0. Tag queue flushed.
  - Reset mid-offer discards the held instruction. A DV arriving in the reset cycle is ignored.
- States: IDLE, OFFER.
- Eligibility: requester i is eligible iff Req_Valid[i]=1 and (we=1 or tag queue not full).
- IDLE:
  - If any requester is eligible, the winner is the first eligible index at or after the pointer, wrapping modulo NUM_REQ.
  - Req_Ready[winner]=1 combinationally in that cycle only.
  - At the posedge: latch the instruction into FIFO_In_Instruction, set Grant_Id=winner, set FIFO_In_Empty=0, pointer <= winner+1 mod NUM_REQ, state -> OFFER.
  - With no eligible requester, state stays IDLE and Req_Ready=0.
- OFFER:
  - Instruction and Grant_Id held stable. Req_Ready all 0.
  - On FIFO_In_Rd_En=1: if we=0, push Grant_Id into the tag queue. Set FIFO_In_Empty=1, state -> IDLE.
  - Rd_En while in IDLE (FIFO_In_Empty=1) is ignored.
- Latency: Valid&Ready at posedge t -> FIFO_In_Empty=0 from t+1. Minimum spacing between grants is 2 cycles (Rd_En cycle, then IDLE).
- Requesters hold Req_Valid and Req_Instruction stable until Ready. Dropping Valid early is legal; the arbiter then re-arbitrates.
- Responses:
  - On FIFO_Out_DV=1 with the tag queue non-empty: pop the head tag. Next cycle Rsp_Valid[tag]=1 for exactly one cycle, with Rsp_Data = FIFO_Out_Data as sampled.
  - DV with the tag queue empty: no Rsp_Valid; Tag_Overflow <= 1, sticky until reset.
  - Push (Rd_En) and pop (DV) in the same cycle are both honoured; occupancy is unchanged.
  - The queue holds up to TAG_DEPTH entries. Read-pointer and write-pointer wrap modulo TAG_DEPTH, with an extra bit used for full/empty.
- Writes generate no response.

Optional Feature:
ARB_STRICT_PRIORITY_EN:
- Defined: the winner is the lowest-index eligible requester; the pointer is unused and held at 0.
- Undefined (default): round-robin as above.
- All other behaviour is identical.

Test Plan:
- Single write: Req_Valid[2]=1, instruction 0x0001_2341 (we=1) -> Req_Ready[2] pulses once; next cycle FIFO_In_Empty=0, FIFO_In_Instruction=0x0001_2341, Grant_Id=2; after Rd_En, Empty=1 and no Rsp_Valid.
- Round-robin: all four Req_Valid held high with writes; controller pops each offer -> grant order 0,1,2,3,0, each grant separated by ≥2 cycles.
- Read return: requester 1 reads, then requester 3 reads; DV with data 0xBEEF, then DV with 0x1234 -> Rsp_Valid[1] with 0xBEEF, then Rsp_Valid[3] with 0x1234, each one cycle long.
- Tag full: 4 reads popped with no DV; requester 0 read and requester 1 write both valid -> requester 1 granted, requester 0 stalls until a DV frees a tag.
- Spurious DV: DV with tag queue empty -> no Rsp_Valid, Tag_Overflow=1 and stays 1 until Rst_n=0.
- Reset mid-offer: Rst_n=0 while in OFFER with 2 tags queued -> next cycle Empty=1, queue empty; a following DV sets Tag_Overflow (proves the queue was flushed).
